// File: rtl/mux_n_rr_pkg.sv
// Shared types and helpers for the N-channel round-robin/fixed multiplexer.
package mux_pkg;

    typedef enum logic {
        MUX_FIXED = 1'b0,
        MUX_RR    = 1'b1
    } mux_mode_e;

    // Index width that stays at least one bit, so N=1 still declares legal vectors.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_rr_if.sv
// Producer/consumer bundle of the multiplexer: N input channels, one output channel, select controls.
interface mux_n_rr_if
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = clog2_min1(N)
);

    mux_mode_e         mode;
    logic [SW-1:0]     sel;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_ch;

    modport master (
        output mode,
        output sel,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_ch
    );

    modport slave (
        input  mode,
        input  sel,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_ch
    );

endinterface

// File: rtl/mux_n_rr_rr_pick.sv
// Combinational round-robin pick: first requester after ptr, searching cyclically.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_valid,
    output logic [SW-1:0] gnt_idx
);

    localparam logic [SW-1:0] LAST = SW'(N - 1);
    localparam logic [SW:0]   NV   = (SW + 1)'(N);

    logic [SW-1:0]  start;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  off;
    logic           found;
    logic [SW:0]    sum;

    // Rotate so the search start lands on bit 0, priority-encode, then rotate the index back.
    always_comb begin
        start = (ptr >= LAST) ? '0 : ptr + SW'(1);
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SW'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= NV) begin
            sum = sum - NV;
        end
        gnt_valid = found;
        gnt_idx   = found ? sum[SW-1:0] : '0;
    end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel W-bit multiplexer with valid/ready flow control, fixed or round-robin
// selection and a single registered output stage.
module mux_n_rr
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = clog2_min1(N)
) (
    input  logic       clk,
    input  logic       rst,
    mux_n_rr_if.slave  bus
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          load;
    logic          fix_valid;
    logic [SW-1:0] fix_idx;
    logic          rr_valid;
    logic [SW-1:0] rr_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [N-1:0]  in_ready;

    // The output register can take a word when empty or being drained this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Equality against every legal index means an out-of-range sel simply matches nothing.
    always_comb begin
        fix_valid = 1'b0;
        fix_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SW'(i) && bus.in_valid[i]) begin
                fix_valid = 1'b1;
                fix_idx   = SW'(i);
            end
        end
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req       (bus.in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        if (bus.mode == MUX_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = fix_valid;
            grant_idx   = fix_idx;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && load && grant_valid && (grant_idx == SW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant_valid) begin
                out_data_d  = grant_data;
                out_ch_d    = grant_idx;
                out_valid_d = 1'b1;
                if (bus.mode == MUX_RR) begin
                    rr_ptr_d = grant_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // ---- output register stage; reset points rr_ptr at N-1 so the first search starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_rr.sv
// Bench for mux_n_rr: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_mux_n_rr;
    import mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int N3 = 3;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;

    int checks = 0;
    int errors = 0;
    bit contract_on = 1'b0;

    mux_n_rr_if #(.N(N),  .W(W)) bus  ();
    mux_n_rr_if #(.N(N3), .W(W)) bus3 ();

    mux_n_rr #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux_n_rr #(.N(N3), .W(W)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state of the output word and the round-robin pointer as plain ints.
    int m_valid = 0, m_data = 0, m_ch = 0, m_ptr = N - 1;
    int n_valid = 0, n_data = 0, n_ch = 0, n_ptr = N - 1;
    logic [N-1:0]   prev_v = '0;
    logic [N-1:0]   prev_r = '0;
    logic [N*W-1:0] prev_d = '0;

    always @(negedge clk) begin : model
        int din[N];
        int vld[N];
        int g, c, s, exp_rdy;
        bit load;

        chk("out_valid", 32'(bus.out_valid), m_valid);
        chk("out_data",  32'(bus.out_data),  m_data);
        chk("out_ch",    32'(bus.out_ch),    m_ch);

        for (int i = 0; i < N; i++) begin
            din[i] = int'(bus.in_data[i*W +: W]);
            vld[i] = bus.in_valid[i] ? 1 : 0;
        end

        g = -1;
        if (bus.mode == MUX_FIXED) begin
            s = int'(bus.sel);
            if (s < N && vld[s] == 1) g = s;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (vld[c] == 1) begin
                    g = c;
                    break;
                end
            end
        end

        load    = (m_valid == 0) || bus.out_ready;
        exp_rdy = (!rst && load && g >= 0) ? (1 << g) : 0;
        chk("in_ready", 32'(bus.in_ready), exp_rdy);

        n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr;
        if (rst) begin
            n_valid = 0; n_data = 0; n_ch = 0; n_ptr = N - 1;
        end else if (load) begin
            if (g >= 0) begin
                n_valid = 1; n_data = din[g]; n_ch = g;
                if (bus.mode == MUX_RR) n_ptr = g;
            end else begin
                n_valid = 0;
            end
        end

        if (contract_on) begin
            for (int i = 0; i < N; i++) begin
                if (prev_v[i] && !prev_r[i]) begin
                    assert (bus.in_valid[i] && bus.in_data[i*W +: W] == prev_d[i*W +: W])
                        else $error("FAIL producer_contract ch%0d", i);
                end
            end
        end
        prev_v = bus.in_valid;
        prev_r = bus.in_ready;
        prev_d = bus.in_data;
    end

    always @(posedge clk) begin
        m_valid <= n_valid; m_data <= n_data; m_ch <= n_ch; m_ptr <= n_ptr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rdy_snap;
        logic [N-1:0] v;
        logic [N*W-1:0] d;

        bus.mode = MUX_RR;  bus.sel = '0;  bus.in_valid = 4'b1111;
        bus.in_data = 32'h13121110;  bus.out_ready = 1'b1;
        bus3.mode = MUX_FIXED;  bus3.sel = '0;  bus3.in_valid = '0;
        bus3.in_data = '0;  bus3.out_ready = 1'b1;

        // Reset state
        step();
        step();
        at_neg();
        chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_out_ch",    32'(bus.out_ch),    32'h0);

        // Fixed select of channel 2
        step();
        rst = 1'b0;  bus.mode = MUX_FIXED;  bus.sel = 2'd2;  bus.in_valid = 4'b0100;
        bus.in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        at_neg();
        chk("fix_in_ready", 32'(bus.in_ready), 32'h4);
        step();
        bus.in_valid = 4'b0000;
        at_neg();
        chk("fix_out_valid", 32'(bus.out_valid), 32'h1);
        chk("fix_out_data",  32'(bus.out_data),  32'hA5);
        chk("fix_out_ch",    32'(bus.out_ch),    32'h2);

        // Round-robin fairness with all channels valid
        step();
        bus.mode = MUX_RR;  bus.in_valid = 4'b1111;  bus.in_data = 32'h13121110;
        for (int i = 0; i < 8; i++) begin
            step();
            at_neg();
            chk("rr_seq_data", 32'(bus.out_data), 32'(8'h10 + (i % 4)));
            chk("rr_seq_ch",   32'(bus.out_ch),   32'(i % 4));
        end

        // Skip and wrap
        step();
        bus.in_valid = 4'b0010;
        step();
        bus.in_valid = 4'b0001;
        at_neg();
        chk("wrap_ch1", 32'(bus.out_ch), 32'h1);
        step();
        bus.in_valid = 4'b1001;
        at_neg();
        chk("wrap_ch0",   32'(bus.out_ch),   32'h0);
        chk("wrap_data0", 32'(bus.out_data), 32'h10);
        step();
        bus.in_valid = 4'b0000;
        at_neg();
        chk("wrap_ch3",   32'(bus.out_ch),   32'h3);
        chk("wrap_data3", 32'(bus.out_data), 32'h13);

        // Backpressure holds the 3C word
        step();
        bus.in_valid = 4'b0010;  bus.in_data = {8'h13, 8'h12, 8'h3C, 8'h10};
        step();
        bus.out_ready = 1'b0;  bus.in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("bp_in_ready",  32'(bus.in_ready),  32'h0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_out_data",  32'(bus.out_data),  32'h3C);
            step();
        end
        bus.out_ready = 1'b1;
        at_neg();
        chk("bp_resume_ready", 32'(bus.in_ready), 32'h4);
        step();
        at_neg();
        chk("bp_resume_d2", 32'(bus.out_data), 32'h12);
        step();
        at_neg();
        chk("bp_resume_d3", 32'(bus.out_data), 32'h13);
        step();
        at_neg();
        chk("bp_resume_d0", 32'(bus.out_data), 32'h10);

        // Reset while a word is held
        step();
        rst = 1'b1;
        at_neg();
        chk("midrst_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        rst = 1'b0;
        at_neg();
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_out_data",  32'(bus.out_data),  32'h0);
        chk("midrst_out_ch",    32'(bus.out_ch),    32'h0);
        chk("midrst_first_rdy", 32'(bus.in_ready),  32'h1);
        step();
        at_neg();
        chk("midrst_first_ch",   32'(bus.out_ch),   32'h0);
        chk("midrst_first_data", 32'(bus.out_data), 32'h10);

        // Randomized traffic; pending (valid, not accepted) channels are held stable
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            rdy_snap = bus.in_ready;
            step();
            v = bus.in_valid;
            d = bus.in_data;
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !rdy_snap[i])) begin
                    v[i] = ($urandom_range(99) < 60);
                    d[i*W +: W] = 8'($urandom);
                end
            end
            bus.in_valid  = v;
            bus.in_data   = d;
            bus.out_ready = ($urandom_range(99) < 70);
            bus.sel       = 2'($urandom);
            if ($urandom_range(15) == 0) bus.mode = (bus.mode == MUX_RR) ? MUX_FIXED : MUX_RR;
            rst = ($urandom_range(199) == 0);
            contract_on = 1'b1;
        end
        contract_on = 1'b0;
        rst = 1'b0;

        // Out-of-range select on a three-channel instance
        step();
        rst3 = 1'b0;  bus3.mode = MUX_FIXED;  bus3.sel = 2'd0;  bus3.in_valid = 3'b111;
        bus3.in_data = {8'h72, 8'h71, 8'h70};
        step();
        bus3.sel = 2'd3;
        at_neg();
        chk("bad_sel_ready",     32'(bus3.in_ready),  32'h0);
        chk("bad_sel_out_valid", 32'(bus3.out_valid), 32'h1);
        chk("bad_sel_out_data",  32'(bus3.out_data),  32'h70);
        step();
        at_neg();
        chk("bad_sel_drained", 32'(bus3.out_valid), 32'h0);
        chk("bad_sel_ready2",  32'(bus3.in_ready),  32'h0);
        step();
        bus3.sel = 2'd2;
        at_neg();
        chk("n3_sel2_ready", 32'(bus3.in_ready), 32'h4);
        step();
        at_neg();
        chk("n3_sel2_data", 32'(bus3.out_data), 32'h72);
        chk("n3_sel2_ch",   32'(bus3.out_ch),   32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
